// File: rtl/commu_rx_chk.sv
// 8N1 serial receiver with 16x oversampling, phase-accumulator baud ticks and
// a pattern checker (fixed 0x55 or incrementing) with saturating counters.
module commu_rx_chk #(
  parameter int unsigned CLK_KHZ = 200000,
  parameter int unsigned OVS     = 16
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        rx,
  input  logic [15:0] tbit_fre,
  input  logic        tx_pattern,
  input  logic        clr_cnt,
  output logic [7:0]  rx_data,
  output logic        rx_vld,
  output logic [31:0] rx_total,
  output logic [15:0] err_cnt,
  output logic        frm_err,
  output logic        now_recv
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [31:0] CLK_LIM   = 32'(CLK_KHZ);
  localparam logic [3:0]  MID_TICK  = 4'(OVS / 2 - 1);
  localparam logic [3:0]  LAST_TICK = 4'(OVS - 1);

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [31:0] acc_q, acc_d, sum_w, inc_w;
  logic        tick_w, stop_sample_w;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [7:0]  exp_q, exp_d, exp_byte_w;
  logic        rx_vld_q, rx_vld_d, frm_err_q, frm_err_d;
  logic [31:0] rx_total_q, rx_total_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  assign inc_w      = 32'(tbit_fre) * 32'(OVS);
  assign sum_w      = acc_q + inc_w;
  assign exp_byte_w = tx_pattern ? exp_q : 8'h55;

  // Baud tick generation and receive FSM.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    tick_w        = 1'b0;
    acc_d         = sum_w;
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    stop_sample_w = 1'b0;

    if (tbit_fre == 16'd0) begin
      acc_d = '0;
    end else if (sum_w >= CLK_LIM) begin
      acc_d  = sum_w - CLK_LIM;
      tick_w = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d    = START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          acc_d      = '0;
        end
      end
      START: begin
        if (tick_w) begin
          if (tick_cnt_q == MID_TICK) begin
            tick_cnt_d = '0;
            state_d    = rx_sync_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick_w) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == LAST_TICK) begin
            shift_d   = {rx_sync_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick_w) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == LAST_TICK) begin
            stop_sample_w = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result reporting and pattern checking; clr_cnt wins over any increment.
  always_comb begin
    rx_vld_d   = 1'b0;
    frm_err_d  = 1'b0;
    rx_data_d  = rx_data_q;
    rx_total_d = rx_total_q;
    err_cnt_d  = err_cnt_q;
    exp_d      = exp_q;

    if (stop_sample_w) begin
      if (rx_sync_q) begin
        rx_vld_d  = 1'b1;
        rx_data_d = shift_q;
        if (tx_pattern) exp_d = shift_q + 8'd1;
        if (shift_q == exp_byte_w) begin
          if (!(&rx_total_q)) rx_total_d = rx_total_q + 32'd1;
        end else begin
          if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + 16'd1;
        end
      end else begin
        frm_err_d = 1'b1;
        if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + 16'd1;
      end
    end

    if (clr_cnt) begin
      rx_total_d = '0;
      err_cnt_d  = '0;
      exp_d      = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      // NOTE: synchronizer resets to the idle-high line level so release creates no false edge.
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= IDLE;
      acc_q      <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_vld_q   <= 1'b0;
      frm_err_q  <= 1'b0;
      rx_total_q <= '0;
      err_cnt_q  <= '0;
      exp_q      <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      state_q    <= state_d;
      acc_q      <= acc_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_vld_q   <= rx_vld_d;
      frm_err_q  <= frm_err_d;
      rx_total_q <= rx_total_d;
      err_cnt_q  <= err_cnt_d;
      exp_q      <= exp_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_vld   = rx_vld_q;
  assign rx_total = rx_total_q;
  assign err_cnt  = err_cnt_q;
  assign frm_err  = frm_err_q;
  assign now_recv = (state_q != IDLE);

endmodule

// File: doc/commu_rx_chk.md
COMMU_RX_CHK -- requirements
Module: commu_rx_chk

Interface
REQ-001 The block SHALL have parameter CLK_KHZ, default 200000, clk_sys frequency in kHz.
REQ-002 The block SHALL have parameter OVS, default 16, oversampling ticks per bit, fixed at 16.
REQ-003 The block SHALL have port clk_sys  input  1  system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port rx  input  1  serial line, asynchronous, idle high.
REQ-006 The block SHALL have port tbit_fre  input  16  bit rate in kbps, for example 10000 = 10 Mbps.
REQ-007 The block SHALL have port tx_pattern  input  1  expected data: 0 = fixed 0x55, 1 = incrementing.
REQ-008 The block SHALL have port clr_cnt  input  1  one-cycle pulse; clears the counters and the expected seed.
REQ-009 The block SHALL have port rx_data  output  8  last received byte.
REQ-010 The block SHALL have port rx_vld  output  1  one-cycle pulse when rx_data is updated.
REQ-011 The block SHALL have port rx_total  output  32  count of bytes received correctly.
REQ-012 The block SHALL have port err_cnt  output  16  count of pattern mismatches plus framing errors.
REQ-013 The block SHALL have port frm_err  output  1  one-cycle pulse on a bad stop bit.
REQ-014 The block SHALL have port now_recv  output  1  high while a frame is in progress.

Function
REQ-015 rx SHALL pass through a 2-FF synchronizer; all decisions SHALL use the synchronized value.
REQ-016 Tick generator: a 32-bit phase accumulator SHALL add tbit_fre*16 each cycle; when the sum is >= CLK_KHZ it SHALL subtract CLK_KHZ and assert tick for one cycle.
REQ-017 The accumulator SHALL be held at 0 while tbit_fre = 0, and no ticks SHALL occur; tbit_fre*16 > CLK_KHZ is unsupported.
REQ-018 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-019 The FSM SHALL have states IDLE, START, DATA and STOP; the tick counter SHALL count 0..15.
REQ-020 IDLE: a synchronized falling edge SHALL move to START, clear the tick counter and clear the accumulator.
REQ-021 START: at tick count 7 (mid-bit) the FSM SHALL move to DATA if rx = 0; if rx = 1 (glitch) it SHALL return to IDLE with no counter change.
REQ-022 DATA: rx SHALL be sampled every 16 ticks into a shift register, LSB first; after bit 7 the FSM SHALL move to STOP.
REQ-023 STOP: the mid-bit sample SHALL return to IDLE immediately, so the next start edge can be detected within the stop bit.
REQ-024 Stop = 1: rx_data SHALL be updated and rx_vld pulsed the cycle after the sample, then the data SHALL be checked.
REQ-025 Stop = 0: frm_err SHALL pulse, err_cnt SHALL increment, rx_vld SHALL stay low, and the expected value SHALL be unchanged.
REQ-026 With tx_pattern = 0 the expected byte SHALL be 0x55.
REQ-027 With tx_pattern = 1 the expected byte SHALL start at 0x00, and after each valid byte expected SHALL become received+1 mod 256 (resync on mismatch; 0xFF wraps to 0x00).
REQ-028 Match SHALL increment rx_total; mismatch SHALL increment err_cnt. Both SHALL update in the same cycle as rx_vld.
REQ-029 rx_total and err_cnt SHALL saturate at all-ones.
REQ-030 clr_cnt SHALL zero rx_total and err_cnt and reset expected to 0x00; it SHALL have priority over a simultaneous increment, and the in-flight frame SHALL continue.
REQ-031 now_recv SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-032 tbit_fre and tx_pattern SHALL be treated as static during a frame; a change mid-frame gives undefined data for that frame only.

Reset
REQ-033 With rst_n = 0 at a clock edge: FSM = IDLE; accumulator, tick counter and shift register = 0; synchronizer = 1; rx_data = 0x00; rx_vld = 0; rx_total = 0; err_cnt = 0; frm_err = 0; now_recv = 0; expected = 0x00.
REQ-034 Reset asserted mid-frame SHALL abandon the frame with no count or pulse; after release, reception SHALL restart on the next falling edge.

Verification
REQ-035 CLK_KHZ = 200000, tbit_fre = 10000, tx_pattern = 1, send 0x00..0x07 back-to-back -> 8 rx_vld pulses, rx_total = 8, err_cnt = 0.
REQ-036 tx_pattern = 0, send 0x55, 0x54, 0x55 -> rx_total = 2, err_cnt = 1.
REQ-037 tx_pattern = 1, send 0xFE, 0xFF, 0x00 after clr_cnt -> first byte mismatches (expected 0x00); then resync -> rx_total = 2, err_cnt = 1.
REQ-038 Send 0xA5 with stop bit = 0 -> frm_err pulse, no rx_vld, err_cnt = 1; a 4-tick low glitch on rx -> no activity, now_recv returns low.
REQ-039 Assert rst_n = 0 during data bit 3, then send 0x00 -> all outputs at reset values, then rx_total = 1.
REQ-040 Set err_cnt to 0xFFFF via forced mismatches plus one more error -> err_cnt stays 0xFFFF; clr_cnt coincident with rx_vld -> counters read 0.
